// File: rtl/load_store_unit.sv
// Load/store unit: converts one RISC-V load/store request at a time into
// word-granular memory accesses. Sub-word loads are extracted and extended;
// byte/halfword stores are done as read-modify-write.
module load_store_unit #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [Width-1:0] req_addr,
  input  logic [Width-1:0] req_wdata,
  output logic             resp_valid,
  output logic [Width-1:0] resp_rdata,
  output logic             resp_error,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [Width-1:0] Addr,
  output logic [Width-1:0] WriteData,
  input  logic [Width-1:0] ReadData
);

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3BU = 3'b100;
  localparam logic [2:0] F3HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StMemRd,
    StMemWait,
    StMemWr,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [Width-1:0] addr_q, addr_d;
  logic [Width-1:0] wdata_q, wdata_d;
  logic [Width-1:0] word_q, word_d;
  logic             error_q, error_d;

  // Misalignment and illegal-funct3 detection for an incoming request.
  function automatic logic req_err(input logic wr, input logic [2:0] f3, input logic [1:0] lane);
    logic e;
    case (f3)
      F3B:     e = 1'b0;
      F3H:     e = lane[0];
      F3W:     e = (lane != 2'b00);
      F3BU:    e = wr;
      F3HU:    e = wr | lane[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Select and extend the addressed byte/half of a memory word.
  function automatic logic [Width-1:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [Width-1:0] word);
    logic [Width-1:0] byte_sh, half_sh, r;
    byte_sh = word >> {lane, 3'b000};
    half_sh = word >> {lane[1], 4'b0000};
    case (f3)
      F3B:     r = {{(Width-8){byte_sh[7]}}, byte_sh[7:0]};
      F3BU:    r = {{(Width-8){1'b0}}, byte_sh[7:0]};
      F3H:     r = {{(Width-16){half_sh[15]}}, half_sh[15:0]};
      F3HU:    r = {{(Width-16){1'b0}}, half_sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  // Merge store data into the previously read word (SW ignores the old word).
  function automatic logic [Width-1:0] merge(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [Width-1:0] word,
                                             input logic [Width-1:0] wdata);
    logic [Width-1:0] m, v, r;
    case (f3)
      F3B: begin
        m = {{(Width-8){1'b0}}, 8'hFF} << {lane, 3'b000};
        v = {{(Width-8){1'b0}}, wdata[7:0]} << {lane, 3'b000};
        r = (word & ~m) | v;
      end
      F3H: begin
        m = {{(Width-16){1'b0}}, 16'hFFFF} << {lane[1], 4'b0000};
        v = {{(Width-16){1'b0}}, wdata[15:0]} << {lane[1], 4'b0000};
        r = (word & ~m) | v;
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Next-state logic: request latching, sequencing and read-word capture.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    error_d  = error_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          error_d  = req_err(req_write, req_funct3, req_addr[1:0]);
          if (error_d) begin
            state_d = StResp;
          end else if (req_write && req_funct3 == F3W) begin
            state_d = StMemWr;
          end else begin
            state_d = StMemRd;
          end
        end
      end
      StMemRd:   state_d = StMemWait;
      StMemWait: begin
        word_d  = ReadData;
        state_d = write_q ? StMemWr : StResp;
      end
      StMemWr:   state_d = StResp;
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      error_q  <= error_d;
    end
  end

  // Outputs decoded from the state register and latched request/word.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_error = resp_valid & error_q;
    resp_rdata = '0;
    if (resp_valid && !error_q && !write_q) begin
      resp_rdata = extract(funct3_q, addr_q[1:0], word_q);
    end
    MemRead   = (state_q == StMemRd);
    MemWrite  = (state_q == StMemWr);
    Addr      = '0;
    if (state_q == StMemRd || state_q == StMemWait || state_q == StMemWr) begin
      Addr = {2'b00, addr_q[Width-1:2]};
    end
    WriteData = MemWrite ? merge(funct3_q, addr_q[1:0], word_q, wdata_q) : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small word memory attached.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  load_store_unit #(.Width(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData)
  );

  always #5 clk = ~clk;

  // Word memory with one-cycle registered read.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (MemWrite) mem[Addr[3:0]] <= WriteData;
    if (MemRead)  ReadData <= mem[Addr[3:0]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Observations of the last transaction.
  int          lat, n_rd, n_wr, rd_cyc, wr_cyc;
  logic [31:0] rd_addr, wr_addr, wr_data, rdata;
  logic        err;

  // Issue one request and observe until the response (bounded), then one idle cycle.
  // req_valid stays high with junk fields while busy; it must be ignored.
  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
    lat = 0; n_rd = 0; n_wr = 0; rd_cyc = 0; wr_cyc = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; rdata = 32'hxxxx_xxxx; err = 1'bx;
    check("ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_write = ~wr; req_funct3 = 3'b111; req_addr = 32'h0000_003C; req_wdata = 32'h5555_5555;
    for (int c = 1; c <= 20; c++) begin
      if (MemRead && MemWrite) check("strobe_excl", 32'd1, 32'd0);
      if (MemRead)  begin n_rd++; rd_cyc = c; rd_addr = Addr; end
      if (MemWrite) begin n_wr++; wr_cyc = c; wr_addr = Addr; wr_data = WriteData; end
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_error;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    check("ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic exp_load(input string tag, input int exp_lat, input logic [31:0] exp_data);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_nrd"}, n_rd, 1);
    check({tag, "_nwr"}, n_wr, 0);
    check({tag, "_rdaddr"}, rd_addr, 32'd4);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_data"}, rdata, exp_data);
  endtask

  task automatic exp_error(input string tag);
    check({tag, "_lat"}, lat, 1);
    check({tag, "_nrd"}, n_rd, 0);
    check({tag, "_nwr"}, n_wr, 0);
    check({tag, "_err"}, {31'd0, err}, 32'd1);
    check({tag, "_data"}, rdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    ReadData = '0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_memread", {31'd0, MemRead}, 32'd0);
    check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_addr", Addr, 32'd0);
    check("rst_wdata", WriteData, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);

    // SW 0x10
    run_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    check("sw_lat", lat, 2);
    check("sw_nrd", n_rd, 0);
    check("sw_nwr", n_wr, 1);
    check("sw_addr", wr_addr, 32'd4);
    check("sw_wdata", wr_data, 32'hDEAD_BEEF);
    check("sw_rdata", rdata, 32'd0);
    check("sw_err", {31'd0, err}, 32'd0);
    check("sw_mem", mem[4], 32'hDEAD_BEEF);

    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    exp_load("lw10", 3, 32'hDEAD_BEEF);

    // SB 0x13: read-modify-write
    run_req(1'b1, 3'b000, 32'h13, 32'h0000_00A5);
    check("sb_lat", lat, 4);
    check("sb_nrd", n_rd, 1);
    check("sb_nwr", n_wr, 1);
    check("sb_rd_to_wr", wr_cyc - rd_cyc, 2);
    check("sb_addr", wr_addr, 32'd4);
    check("sb_wdata", wr_data, 32'hA5AD_BEEF);
    check("sb_mem", mem[4], 32'hA5AD_BEEF);

    run_req(1'b0, 3'b000, 32'h13, 32'h0);
    exp_load("lb13", 3, 32'hFFFF_FFA5);
    run_req(1'b0, 3'b100, 32'h13, 32'h0);
    exp_load("lbu13", 3, 32'h0000_00A5);

    // SH 0x12
    run_req(1'b1, 3'b001, 32'h12, 32'h0000_1234);
    check("sh_lat", lat, 4);
    check("sh_wdata", wr_data, 32'h1234_BEEF);
    check("sh_mem", mem[4], 32'h1234_BEEF);

    run_req(1'b0, 3'b001, 32'h10, 32'h0);
    exp_load("lh10", 3, 32'hFFFF_BEEF);
    run_req(1'b0, 3'b101, 32'h10, 32'h0);
    exp_load("lhu10", 3, 32'h0000_BEEF);
    run_req(1'b0, 3'b001, 32'h12, 32'h0);
    exp_load("lh12", 3, 32'h0000_1234);
    run_req(1'b0, 3'b000, 32'h11, 32'h0);
    exp_load("lb11", 3, 32'hFFFF_FFBE);
    run_req(1'b0, 3'b100, 32'h11, 32'h0);
    exp_load("lbu11", 3, 32'h0000_00BE);

    // Errors
    run_req(1'b0, 3'b010, 32'h11, 32'h0);
    exp_error("lw11");
    run_req(1'b1, 3'b001, 32'h13, 32'hFFFF_FFFF);
    exp_error("sh13");
    check("sh13_mem", mem[4], 32'h1234_BEEF);
    run_req(1'b0, 3'b011, 32'h10, 32'h0);
    exp_error("ld_f3_011");
    run_req(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF);
    exp_error("st_f3_100");
    check("st_f3_100_mem", mem[4], 32'h1234_BEEF);

    // Reset during MEM_WAIT of an LW
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_memread", {31'd0, MemRead}, 32'd1);
    @(posedge clk); #1;
    check("mid_wait_addr", Addr, 32'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_ready", {31'd0, req_ready}, 32'd1);
    check("mid_addr", Addr, 32'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 4; c++) begin
        if (resp_valid) seen++;
        @(posedge clk); #1;
      end
      check("mid_no_resp", seen, 0);
    end
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    exp_load("lw_after_rst", 3, 32'h1234_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit that sits between the execute stage and the word-wide data memory, acting as the initiator on the memory's MemRead/MemWrite/Addr/WriteData/ReadData interface. It accepts one RISC-V load or store request at a time and converts the byte address to a word index. Sub-word loads are extracted and extended. Byte and halfword stores are performed as read-modify-write, since the memory is word-granular with a one-cycle registered read.

## Interface
- Width, 32, data and address width; only 32 is supported.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Stores accept only 000/001/010.
- req_addr  in  Width  byte address.
- req_wdata  in  Width  store data (low bits used for B/H).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  Width  extended load result; 0 for stores and errors.
- resp_error  out  1  misaligned or illegal funct3; valid with resp_valid.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- Addr  out  Width  word index = {2'b00, addr[Width-1:2]}.
- WriteData  out  Width  word to write.
- ReadData  in  Width  memory read word, valid the cycle after a MemRead cycle.

## Operation
- States: IDLE, MEM_RD, MEM_WAIT, MEM_WR, RESP. All outputs are registered and driven from state.
- req_ready = 1 only in IDLE. Accept occurs on a clock edge with req_valid & req_ready. At accept, write, funct3, addr and wdata are latched; request inputs are ignored after that.
- Error check at accept:
  - H/HU with addr[0] = 1 is an error.
  - W with addr[1:0] != 0 is an error.
  - Load funct3 011/110/111 is an error.
  - Store funct3 other than 000/001/010 is an error.
- Transitions out of IDLE on accept:
  - Error: IDLE -> RESP with resp_error = 1. No memory access.
  - Load: IDLE -> MEM_RD -> MEM_WAIT -> RESP.
  - SW: IDLE -> MEM_WR -> RESP.
  - SB/SH: IDLE -> MEM_RD -> MEM_WAIT -> MEM_WR -> RESP.
- RESP -> IDLE unconditionally.
- Strobes: MemRead = 1 exactly in MEM_RD; MemWrite = 1 exactly in MEM_WR. The two are never high together.
- Addr is held at the latched word index from MEM_RD through MEM_WR, and is 0 in IDLE.
- MEM_WAIT latches ReadData into an internal word register.
- Load extract, with lane = addr[1:0]:
  - B/BU take byte [8*lane+7 : 8*lane].
  - H/HU take half [16*addr[1]+15 : 16*addr[1]].
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
- Store merge:
  - SB replaces the addressed byte lane of the latched word with wdata[7:0].
  - SH replaces the addressed half with wdata[15:0].
  - SW writes wdata unmodified.
- No address range check; the memory depth is the caller's responsibility.

## Timing
- Reset values: state IDLE; req_ready = 1; resp_valid, resp_error, MemRead, MemWrite = 0; Addr, WriteData, resp_rdata = 0.
- Latency, counted in cycles after the accept edge until resp_valid is high:
  - Error: 1.
  - SW: 2.
  - Load: 3.
  - SB/SH: 4.
- resp_valid lasts exactly one cycle. req_ready returns to 1 the cycle after RESP.
- Back-to-back: a new request can be accepted on the edge that ends the first IDLE cycle after RESP. There is no same-cycle accept during RESP.
- Reset mid-operation: the next state is IDLE and no resp_valid is produced. A MemWrite already presented in the cycle when rst is high still commits, because the memory has no reset; the strobe drops after that edge.
- req_valid held high while busy is not accepted and has no effect.

## Test plan
- Reset: rst high 2 cycles, then low -> req_ready = 1; MemRead = MemWrite = resp_valid = 0; Addr = 0.
- SW 0x10 with 0xDEADBEEF:
  - MemWrite for 1 cycle, Addr = 4, WriteData = 0xDEADBEEF.
  - resp_valid 2 cycles after accept.
  - Then LW 0x10 -> one MemRead cycle, resp_rdata = 0xDEADBEEF 3 cycles after accept, resp_error = 0.
- SB 0x13 with wdata 0x000000A5 on word 0xDEADBEEF:
  - MemRead, then MemWrite 2 cycles later, with Addr = 4 and WriteData = 0xA5ADBEEF; resp 4 cycles after accept.
  - LB 0x13 -> 0xFFFFFFA5. LBU 0x13 -> 0x000000A5.
- SH 0x12 with 0x00001234 on word 0xA5ADBEEF:
  - WriteData = 0x1234BEEF.
  - LH 0x10 -> 0xFFFFBEEF. LHU 0x10 -> 0x0000BEEF. LH 0x12 -> 0x00001234.
- Errors:
  - LW 0x11 -> no strobes; resp_valid 1 cycle after accept with resp_error = 1 and resp_rdata = 0.
  - SH 0x13 -> same, and memory word unchanged.
  - Load funct3 = 011 -> same.
- Reset during MEM_WAIT of an LW -> no resp_valid; req_ready = 1 the cycle after rst drops; a following LW completes normally.
